// File: rtl/chess_pkg.sv
// Shared piece/state encodings and colour/delta helpers for the move checker.
package chess_pkg;

  typedef enum logic [3:0] {
    WRook   = 4'd0,
    WKnight = 4'd1,
    WBishop = 4'd2,
    WQueen  = 4'd3,
    WKing   = 4'd4,
    WPawn   = 4'd5,
    BRook   = 4'd6,
    BKnight = 4'd7,
    BBishop = 4'd8,
    BQueen  = 4'd9,
    BKing   = 4'd10,
    BPawn   = 4'd11,
    Empty   = 4'd12
  } piece_t;

  typedef enum logic [1:0] {StIdle, StDecode, StWalk, StDone} state_t;

  function automatic logic is_white(int code, int black_base);
    return (code >= 0) && (code < black_base);
  endfunction

  function automatic logic is_black(int code, int black_base);
    return (code >= black_base) && (code <= black_base + 5);
  endfunction

  function automatic logic same_colour(int a, int b, int black_base);
    return (is_white(a, black_base) && is_white(b, black_base)) ||
           (is_black(a, black_base) && is_black(b, black_base));
  endfunction

  function automatic int abs_delta(int d);
    return (d < 0) ? -d : d;
  endfunction

  function automatic int sign_step(int d);
    return (d > 0) ? 1 : ((d < 0) ? -1 : 0);
  endfunction

endpackage

// File: rtl/move_geometry.sv
// Combinational move-shape classifier; piece is the colour-stripped (white) code.
module move_geometry
  import chess_pkg::*;
#(
  parameter int BOARD_DIM = 8,
  parameter int COORD_W   = $clog2(BOARD_DIM)
) (
  input  piece_t                    piece,
  input  logic                      black,
  input  logic signed [COORD_W:0]   dx,
  input  logic signed [COORD_W:0]   dy,
  input  logic        [COORD_W-1:0] src_row,
  input  logic                      dst_empty,
  output logic                      geom_ok,
  output logic                      needs_walk,
  output logic signed [COORD_W:0]   step_x,
  output logic signed [COORD_W:0]   step_y
);

  localparam logic [COORD_W-1:0] WhiteStart = COORD_W'(1);
  localparam logic [COORD_W-1:0] BlackStart = COORD_W'(BOARD_DIM - 2);
  localparam logic [COORD_W:0]   One        = (COORD_W+1)'(1);
  localparam logic [COORD_W:0]   Two        = (COORD_W+1)'(2);

  logic        [COORD_W:0] adx, ady, maxd;
  logic signed [COORD_W:0] fwd, fwd2;
  logic                    rook_g, bishop_g, knight_g, pawn_dbl, pawn_ok;

  always_comb begin
    adx      = (COORD_W+1)'(abs_delta(int'(dx)));
    ady      = (COORD_W+1)'(abs_delta(int'(dy)));
    step_x   = (COORD_W+1)'(sign_step(int'(dx)));
    step_y   = (COORD_W+1)'(sign_step(int'(dy)));
    maxd     = (adx > ady) ? adx : ady;
    fwd      = (COORD_W+1)'(black ? -1 : 1);
    fwd2     = (COORD_W+1)'(black ? -2 : 2);
    rook_g   = (dx == '0) != (dy == '0);
    bishop_g = (adx == ady) && (adx != '0);
    knight_g = ((adx == One) && (ady == Two)) || ((adx == Two) && (ady == One));
    pawn_dbl = (dx == '0) && (dy == fwd2) && dst_empty &&
               (src_row == (black ? BlackStart : WhiteStart));
    // Diagonal pawn step needs an occupant; colour was already screened by the caller.
    pawn_ok  = ((dx == '0) && (dy == fwd) && dst_empty) || pawn_dbl ||
               ((adx == One) && (dy == fwd) && !dst_empty);

    geom_ok = 1'b0;
    case (piece)
      WRook:   geom_ok = rook_g;
      WKnight: geom_ok = knight_g;
      WBishop: geom_ok = bishop_g;
      WQueen:  geom_ok = rook_g || bishop_g;
      WKing:   geom_ok = (maxd == One);
      WPawn:   geom_ok = pawn_ok;
      default: geom_ok = 1'b0;
    endcase

    needs_walk = geom_ok && (maxd > One) &&
                 ((piece == WRook) || (piece == WBishop) || (piece == WQueen) ||
                  ((piece == WPawn) && pawn_dbl));
  end

endmodule

// File: rtl/move_validator.sv
// Handshaked single-move legality checker; walks sliding paths one square per clock.
module move_validator
  import chess_pkg::*;
#(
  parameter int BOARD_DIM  = 8,
  parameter int COORD_W    = $clog2(BOARD_DIM),
  parameter int PIECE_W    = 4,
  parameter int EMPTY_CODE = 12,
  parameter int BLACK_BASE = 6
) (
  input  logic                                            clk,
  input  logic                                            reset,
  input  logic                                            start,
  input  logic [COORD_W-1:0]                              old_x,
  input  logic [COORD_W-1:0]                              old_y,
  input  logic [COORD_W-1:0]                              new_x,
  input  logic [COORD_W-1:0]                              new_y,
  input  logic [BOARD_DIM-1:0][BOARD_DIM-1:0][PIECE_W-1:0] board_in,
  output logic                                            busy,
  output logic                                            done,
  output logic                                            valid_move
);

  localparam logic [COORD_W:0]   DimC  = (COORD_W+1)'(BOARD_DIM);
  localparam logic [PIECE_W-1:0] EmptyC = PIECE_W'(EMPTY_CODE);
  localparam logic [PIECE_W-1:0] BaseC  = PIECE_W'(BLACK_BASE);
  localparam logic [PIECE_W-1:0] LastC  = PIECE_W'(BLACK_BASE + 5);

  state_t                  state;
  logic [COORD_W-1:0]      ox, oy, nx, ny;
  logic [COORD_W:0]        cur_x, cur_y, stp_x, stp_y;

  logic [PIECE_W-1:0]      src, dst, kind, wcode;
  logic                    src_black, dst_empty, reject;
  logic signed [COORD_W:0] dx, dy, gstep_x, gstep_y;
  logic                    geom_ok, needs_walk, at_dest;
  logic [COORD_W:0]        nxt_x, nxt_y;

  always_comb begin
    src       = board_in[oy][ox];
    dst       = board_in[ny][nx];
    src_black = is_black(int'(src), BLACK_BASE);
    kind      = src_black ? (src - BaseC) : src;
    dx        = {1'b0, nx} - {1'b0, ox};
    dy        = {1'b0, ny} - {1'b0, oy};
    dst_empty = (dst == EmptyC);
    reject    = ({1'b0, ox} >= DimC) || ({1'b0, oy} >= DimC) ||
                ({1'b0, nx} >= DimC) || ({1'b0, ny} >= DimC) ||
                ((ox == nx) && (oy == ny)) ||
                (src == EmptyC) || (src > LastC) ||
                (!dst_empty && same_colour(int'(src), int'(dst), BLACK_BASE));

    wcode   = board_in[cur_y[COORD_W-1:0]][cur_x[COORD_W-1:0]];
    nxt_x   = cur_x + stp_x;
    nxt_y   = cur_y + stp_y;
    at_dest = (nxt_x == {1'b0, nx}) && (nxt_y == {1'b0, ny});
  end

  move_geometry #(
    .BOARD_DIM (BOARD_DIM),
    .COORD_W   (COORD_W)
  ) u_geom (
    .piece      (piece_t'(kind)),
    .black      (src_black),
    .dx         (dx),
    .dy         (dy),
    .src_row    (oy),
    .dst_empty  (dst_empty),
    .geom_ok    (geom_ok),
    .needs_walk (needs_walk),
    .step_x     (gstep_x),
    .step_y     (gstep_y)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= StIdle;
      busy       <= 1'b0;
      done       <= 1'b0;
      valid_move <= 1'b0;
      ox         <= '0;
      oy         <= '0;
      nx         <= '0;
      ny         <= '0;
      cur_x      <= '0;
      cur_y      <= '0;
      stp_x      <= '0;
      stp_y      <= '0;
    end else begin
      case (state)
        StIdle: begin
          done <= 1'b0;
          if (start) begin
            ox    <= old_x;
            oy    <= old_y;
            nx    <= new_x;
            ny    <= new_y;
            busy  <= 1'b1;
            state <= StDecode;
          end
        end
        StDecode: begin
          if (reject || !geom_ok) begin
            valid_move <= 1'b0;
            done       <= 1'b1;
            state      <= StDone;
          end else if (needs_walk) begin
            cur_x <= {1'b0, ox} + gstep_x;
            cur_y <= {1'b0, oy} + gstep_y;
            stp_x <= gstep_x;
            stp_y <= gstep_y;
            state <= StWalk;
          end else begin
            valid_move <= 1'b1;
            done       <= 1'b1;
            state      <= StDone;
          end
        end
        StWalk: begin
          if (wcode != EmptyC) begin
            valid_move <= 1'b0;
            done       <= 1'b1;
            state      <= StDone;
          end else if (at_dest) begin
            valid_move <= 1'b1;
            done       <= 1'b1;
            state      <= StDone;
          end else begin
            cur_x <= nxt_x;
            cur_y <= nxt_y;
          end
        end
        StDone: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_move_validator.sv
// Directed vector bench for move_validator: verdict, latency and busy/done handshake.
module tb_move_validator;

  localparam int D  = 8;
  localparam int CW = 3;
  localparam int PW = 4;
  localparam int E  = 12;

  logic                         clk = 1'b0;
  logic                         reset, start;
  logic [CW-1:0]                old_x, old_y, new_x, new_y;
  logic [D-1:0][D-1:0][PW-1:0]  board;
  logic                         busy, done, valid_move;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  move_validator #(
    .BOARD_DIM  (D),
    .COORD_W    (CW),
    .PIECE_W    (PW),
    .EMPTY_CODE (E),
    .BLACK_BASE (6)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .old_x      (old_x),
    .old_y      (old_y),
    .new_x      (new_x),
    .new_y      (new_y),
    .board_in   (board),
    .busy       (busy),
    .done       (done),
    .valid_move (valid_move)
  );

  typedef struct {
    int ox, oy, nx, ny;
    int src, dst;
    int has_blk, bx, by, bcode;
    int exp_valid, exp_lat;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic build(input vec_t v);
    for (int y = 0; y < D; y++)
      for (int x = 0; x < D; x++)
        board[y][x] = PW'(E);
    board[v.ny][v.nx] = PW'(v.dst);
    board[v.oy][v.ox] = PW'(v.src);
    if (v.has_blk != 0) board[v.by][v.bx] = PW'(v.bcode);
  endtask

  // Called at a negedge; start is seen by the next posedge, lat counts negedges to done.
  task automatic run_req(input int ox, input int oy, input int nx, input int ny,
                         output int lat, output int bcnt, output int v);
    int n;
    old_x = CW'(ox);
    old_y = CW'(oy);
    new_x = CW'(nx);
    new_y = CW'(ny);
    start = 1'b1;
    bcnt  = 0;
    for (n = 1; n <= 40; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) bcnt++;
      if (done) break;
    end
    lat = n;
    v   = int'(valid_move);
  endtask

  initial begin
    int lat, bcnt, v, dcnt;
    vec_t t;

    // ox oy nx ny src dst blk bx by bcode valid lat
    vecs[0]  = '{1, 0, 2, 2, 1, E, 0, 0, 0, 0, 1, 2};   // knight
    vecs[1]  = '{0, 0, 0, 7, 0, E, 1, 0, 3, 5, 0, 5};   // rook blocked at (0,3)
    vecs[2]  = '{3, 7, 7, 3, 9, 5, 0, 0, 0, 0, 1, 5};   // black queen captures
    vecs[3]  = '{4, 1, 4, 3, 5, E, 0, 0, 0, 0, 1, 3};   // pawn double, clear
    vecs[4]  = '{4, 1, 4, 3, 5, E, 1, 4, 2, 11, 0, 3};  // pawn double, blocked
    vecs[5]  = '{4, 2, 4, 4, 5, E, 0, 0, 0, 0, 0, 2};   // double off start row
    vecs[6]  = '{4, 1, 5, 2, 5, 7, 0, 0, 0, 0, 1, 2};   // pawn capture
    vecs[7]  = '{4, 1, 5, 2, 5, E, 0, 0, 0, 0, 0, 2};   // pawn diag onto empty
    vecs[8]  = '{2, 2, 2, 3, E, E, 0, 0, 0, 0, 0, 2};   // empty source
    vecs[9]  = '{3, 3, 3, 3, 0, E, 0, 0, 0, 0, 0, 2};   // same square
    vecs[10] = '{4, 0, 6, 0, 4, E, 0, 0, 0, 0, 0, 2};   // king two squares
    vecs[11] = '{2, 0, 4, 2, 2, 5, 0, 0, 0, 0, 0, 2};   // bishop onto own piece
    vecs[12] = '{3, 6, 3, 4, 11, E, 0, 0, 0, 0, 1, 3};  // black pawn double
    vecs[13] = '{0, 0, 0, 7, 0, E, 0, 0, 0, 0, 1, 8};   // rook full file
    vecs[14] = '{4, 0, 5, 1, 4, 6, 0, 0, 0, 0, 1, 2};   // king captures
    vecs[15] = '{2, 0, 4, 1, 2, E, 0, 0, 0, 0, 0, 2};   // bishop bad shape
    vecs[16] = '{6, 7, 5, 5, 7, 11, 0, 0, 0, 0, 0, 2};  // black knight onto own
    vecs[17] = '{3, 0, 3, 1, 3, E, 0, 0, 0, 0, 1, 2};   // queen one step

    reset = 1'b1;
    start = 1'b0;
    old_x = '0; old_y = '0; new_x = '0; new_y = '0;
    build(vecs[8]);
    repeat (2) @(negedge clk);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_valid", int'(valid_move), 0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 18; i++) begin
      build(vecs[i]);
      run_req(vecs[i].ox, vecs[i].oy, vecs[i].nx, vecs[i].ny, lat, bcnt, v);
      check($sformatf("v%0d_valid", i), v, vecs[i].exp_valid);
      check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      check($sformatf("v%0d_busy_cycles", i), bcnt, vecs[i].exp_lat);
      @(negedge clk);
      check($sformatf("v%0d_idle_busy", i), int'(busy), 0);
      check($sformatf("v%0d_idle_done", i), int'(done), 0);
    end

    // Reset in the middle of a rook walk: outputs clear at once, no done follows.
    t = vecs[13];
    build(t);
    old_x = 0; old_y = 0; new_x = 0; new_y = 7;
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    check("walk_busy_before_reset", int'(busy), 1);
    reset = 1'b1;
    #1;
    check("midreset_busy", int'(busy), 0);
    check("midreset_done", int'(done), 0);
    check("midreset_valid", int'(valid_move), 0);
    @(negedge clk);
    reset = 1'b0;
    dcnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    check("midreset_no_done", dcnt, 0);

    // start held while busy, with coordinates changed to a reject case: must be ignored.
    old_x = 0; old_y = 0; new_x = 0; new_y = 7;
    start = 1'b1;
    bcnt = 0;
    for (lat = 1; lat <= 40; lat++) begin
      @(negedge clk);
      old_x = 5; old_y = 5; new_x = 5; new_y = 5;
      if (done) break;
    end
    start = 1'b0;
    check("busy_start_valid", int'(valid_move), 1);
    check("busy_start_latency", lat, 8);
    dcnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    check("busy_start_no_extra_done", dcnt, 0);

    // Back-to-back: start raised in the DONE cycle is ignored, accepted one cycle later.
    build(vecs[0]);
    run_req(1, 0, 2, 2, lat, bcnt, v);
    check("b2b_first_valid", v, 1);
    build(vecs[10]);
    old_x = 4; old_y = 0; new_x = 6; new_y = 0;
    start = 1'b1;
    for (lat = 1; lat <= 40; lat++) begin
      @(negedge clk);
      if (lat == 2) start = 1'b0;
      if (done) break;
    end
    start = 1'b0;
    check("b2b_second_latency", lat, 3);
    check("b2b_second_valid", int'(valid_move), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
